// File: rtl/ssd1306_pkg.sv
// Shared types and default panel geometry for the SSD1306 frame streamer.
package ssd1306_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    SYNC_WAIT,
    READ,
    LATCH,
    WRITE,
    WRITE_WAIT
  } state_e;

  localparam int unsigned OLED_COLS     = 128;
  localparam int unsigned OLED_PAGES_32 = 4;
  localparam int unsigned OLED_PAGES_64 = 8;

endpackage

// File: rtl/ssd1306_refresh_timer.sv
// Frame period counter plus a sticky pending flag; timer expiries and
// external requests coalesce into a single pending frame.
module ssd1306_refresh_timer #(
  parameter int unsigned FRAME_PERIOD = 1200000,
  parameter int unsigned TMR_W        = 21
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable_i,
  input  logic refresh_req_i,
  input  logic clear_i,
  output logic pending_o
);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(FRAME_PERIOD - 1);

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             pend_q, pend_d;
  logic             expire;

  always_comb begin
    expire = enable_i && (tmr_q == TMR_LAST);
    tmr_d  = (!enable_i || expire) ? '0 : tmr_q + 1'b1;
    // A new event in the same cycle as the clear survives, so nothing is lost.
    pend_d = (pend_q & ~clear_i) | expire | refresh_req_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tmr_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      tmr_q  <= tmr_d;
      pend_q <= pend_d;
    end
  end

  assign pending_o = pend_q;

endmodule

// File: rtl/ssd1306_frame_streamer.sv
// Streams one sync strobe plus WIDTH*PAGES framebuffer bytes to the SSD1306
// driver per frame, with one strobe per ready low->high handshake.
module ssd1306_frame_streamer
  import ssd1306_pkg::*;
#(
  parameter int unsigned WIDTH        = OLED_COLS,
  parameter int unsigned PAGES        = OLED_PAGES_32,
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned FRAME_PERIOD = 1200000,
  parameter int unsigned TMR_W        = 21
) (
  input  logic              clk_in,
  input  logic              resetn_in,
  input  logic              enable_in,
  input  logic              refresh_req_in,
  output logic              fb_rd_en,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [7:0]        fb_data_in,
  output logic [7:0]        drv_data,
  output logic              drv_write_stb,
  output logic              drv_sync_stb,
  input  logic              drv_ready,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * PAGES - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_q;
  logic              rd_en_q, wr_stb_q, sync_stb_q, busy_q, done_q, seen_low_q;
  logic              pending, start;

  assign start = (state_q == IDLE) && pending && drv_ready;

  ssd1306_refresh_timer #(
    .FRAME_PERIOD(FRAME_PERIOD),
    .TMR_W       (TMR_W)
  ) u_timer (
    .clk_i        (clk_in),
    .rst_ni       (resetn_in),
    .enable_i     (enable_in),
    .refresh_req_i(refresh_req_in),
    .clear_i      (start),
    .pending_o    (pending)
  );

  always_ff @(posedge clk_in) begin
    if (!resetn_in) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      rd_en_q    <= 1'b0;
      wr_stb_q   <= 1'b0;
      sync_stb_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      seen_low_q <= 1'b0;
    end else begin
      rd_en_q    <= 1'b0;
      wr_stb_q   <= 1'b0;
      sync_stb_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          addr_q     <= '0;
          busy_q     <= 1'b1;
          sync_stb_q <= 1'b1;
          state_q    <= SYNC;
        end
        SYNC: begin
          seen_low_q <= 1'b0;
          state_q    <= SYNC_WAIT;
        end
        SYNC_WAIT: begin
          if (!drv_ready) seen_low_q <= 1'b1;
          else if (seen_low_q) begin
            rd_en_q <= 1'b1;
            state_q <= READ;
          end
        end
        READ:  state_q <= LATCH;
        LATCH: begin
          data_q  <= fb_data_in;
          state_q <= WRITE;
        end
        WRITE: if (drv_ready) begin
          // Strobe shows in the first WRITE_WAIT cycle, while ready is still high.
          wr_stb_q   <= 1'b1;
          seen_low_q <= 1'b0;
          state_q    <= WRITE_WAIT;
        end
        WRITE_WAIT: begin
          if (!drv_ready) seen_low_q <= 1'b1;
          else if (seen_low_q) begin
            if (addr_q == LAST_ADDR) begin
              addr_q  <= '0;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              addr_q  <= addr_q + 1'b1;
              rd_en_q <= 1'b1;
              state_q <= READ;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fb_rd_en      = rd_en_q;
  assign fb_addr       = addr_q;
  assign drv_data      = data_q;
  assign drv_write_stb = wr_stb_q;
  assign drv_sync_stb  = sync_stb_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;

endmodule

// File: tb/tb_ssd1306_frame_streamer.sv
// Scoreboard bench: stimulus queues expected sync/data strobes, a monitor
// pops and compares them as the streamer emits strobes to a driver model.
module tb_ssd1306_frame_streamer;

  localparam int W = 4, P = 2, AW = 4, FP = 200, TW = 8, NB = W * P;

  logic          clk = 1'b0;
  logic          resetn = 1'b0, enable = 1'b0, req = 1'b0;
  logic          fb_rd_en, drv_write_stb, drv_sync_stb, drv_ready, busy, frame_done;
  logic [AW-1:0] fb_addr;
  logic [7:0]    fb_data, drv_data;
  logic          drv_hold = 1'b0;
  int unsigned   drv_busy = 0;
  int            cyc = 0;
  logic [7:0]    fb_mem [0:15];

  typedef struct packed {logic is_sync; logic [7:0] data;} exp_t;
  exp_t sb[$];
  int   sync_cyc[$];
  int   checks = 0, errors = 0, done_cnt = 0, strobe_cnt = 0, wr_cnt = 0;

  ssd1306_frame_streamer #(
    .WIDTH(W), .PAGES(P), .ADDR_W(AW), .FRAME_PERIOD(FP), .TMR_W(TW)
  ) dut (
    .clk_in(clk), .resetn_in(resetn), .enable_in(enable), .refresh_req_in(req),
    .fb_rd_en(fb_rd_en), .fb_addr(fb_addr), .fb_data_in(fb_data),
    .drv_data(drv_data), .drv_write_stb(drv_write_stb), .drv_sync_stb(drv_sync_stb),
    .drv_ready(drv_ready), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Driver model: ready drops for 5 cycles after each accepted strobe.
  assign drv_ready = !drv_hold && (drv_busy == 0);
  always_ff @(posedge clk) begin
    cyc <= cyc + 1;
    if (!resetn) drv_busy <= 0;
    else if (drv_sync_stb || drv_write_stb) drv_busy <= 5;
    else if (drv_busy != 0) drv_busy <= drv_busy - 1;
    if (fb_rd_en) fb_data <= fb_mem[fb_addr];
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame();
    sb.push_back('{1'b1, 8'h00});
    for (int i = 0; i < NB; i++) sb.push_back('{1'b0, 8'(8'hA0 + i)});
  endtask

  task automatic pulse_req();
    @(negedge clk) req = 1'b1;
    @(negedge clk) req = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (drv_sync_stb || drv_write_stb) begin
          strobe_cnt++;
          chk("strobe_ready", drv_ready, 1);
          chk("busy_in_frame", busy, 1);
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_strobe: got sync=%0b data=%0h expected none",
                     drv_sync_stb, drv_data);
          end else begin
            e = sb.pop_front();
            chk("strobe_kind", drv_sync_stb, e.is_sync);
            if (!e.is_sync) chk("data_byte", drv_data, e.data);
          end
          if (drv_sync_stb) sync_cyc.push_back(cyc);
          else wr_cnt++;
        end
        if (frame_done) done_cnt++;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin : stim
    int base, wbase, rel;
    for (int i = 0; i < 16; i++) fb_mem[i] = 8'(8'hA0 + i);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", fb_rd_en, 0);
    chk("rst_addr", fb_addr, 0);
    chk("rst_data", drv_data, 0);
    chk("rst_sync", drv_sync_stb, 0);
    chk("rst_write", drv_write_stb, 0);
    chk("rst_done", frame_done, 0);
    resetn = 1'b1;
    repeat (500) @(negedge clk);
    chk("idle_no_strobes", strobe_cnt, 0);

    // Single requested frame
    push_frame(); base = done_cnt;
    pulse_req();
    repeat (200) @(negedge clk);
    chk("req_frame_done", done_cnt - base, 1);
    chk("req_sb_empty", sb.size(), 0);

    // Periodic refresh
    repeat (5) push_frame();
    sync_cyc.delete(); base = done_cnt;
    enable = 1'b1;
    repeat (1010) @(negedge clk);
    enable = 1'b0;
    repeat (300) @(negedge clk);
    chk("periodic_done", done_cnt - base, 5);
    chk("periodic_syncs", sync_cyc.size(), 5);
    for (int i = 1; i < sync_cyc.size(); i++)
      chk("periodic_spacing", sync_cyc[i] - sync_cyc[i-1], FP);
    chk("periodic_sb_empty", sb.size(), 0);

    // Two requests during a frame coalesce into one extra frame
    repeat (2) push_frame(); base = done_cnt;
    pulse_req();
    repeat (30) @(negedge clk);
    pulse_req();
    repeat (5) @(negedge clk);
    pulse_req();
    repeat (400) @(negedge clk);
    chk("coalesce_done", done_cnt - base, 2);
    chk("coalesce_sb_empty", sb.size(), 0);

    // Driver still initialising
    push_frame(); base = strobe_cnt;
    drv_hold = 1'b1;
    pulse_req();
    repeat (300) @(negedge clk);
    chk("init_no_strobe", strobe_cnt - base, 0);
    sync_cyc.delete(); base = done_cnt;
    rel = cyc;
    drv_hold = 1'b0;
    repeat (200) @(negedge clk);
    chk("init_sync_count", sync_cyc.size(), 1);
    if (sync_cyc.size() > 0) chk("init_sync_latency", sync_cyc[0] - rel, 1);
    chk("init_done", done_cnt - base, 1);
    chk("init_sb_empty", sb.size(), 0);

    // Reset in the middle of a frame
    push_frame(); wbase = wr_cnt;
    pulse_req();
    for (int k = 0; k < 200 && wr_cnt < wbase + 4; k++) @(negedge clk);
    chk("midrst_reached_byte4", wr_cnt - wbase, 4);
    resetn = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_sync", drv_sync_stb, 0);
    chk("midrst_write", drv_write_stb, 0);
    chk("midrst_rd_en", fb_rd_en, 0);
    chk("midrst_addr", fb_addr, 0);
    chk("midrst_data", drv_data, 0);
    sb.delete();
    @(negedge clk) resetn = 1'b1;
    push_frame(); base = done_cnt;
    pulse_req();
    repeat (200) @(negedge clk);
    chk("post_rst_done", done_cnt - base, 1);
    chk("post_rst_bytes", wr_cnt - wbase, 4 + NB);
    chk("post_rst_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
